// File: rtl/heap_alloc_if.sv
// Request/response bundle between the core's cell-construction logic and the heap allocator.
// The core drives the master side and the allocator is the slave.
interface heap_alloc_if #(
    parameter int unsigned DATA_SZ = 16,
    parameter int unsigned ADDR_SZ = 8
);
    logic               alloc;
    logic [DATA_SZ-1:0] data;
    logic [DATA_SZ-1:0] alloc_addr;
    logic               free;
    logic [DATA_SZ-1:0] free_addr;
    logic               wr;
    logic [DATA_SZ-1:0] waddr;
    logic [DATA_SZ-1:0] wdata;
    logic               rd;
    logic [DATA_SZ-1:0] raddr;
    logic [DATA_SZ-1:0] rdata;
    logic               rdata_vld;
    logic [ADDR_SZ:0]   free_cnt;
    logic [ADDR_SZ:0]   used_cnt;
    logic               err;
    logic [1:0]         err_code;

    modport master (
        output alloc, data, free, free_addr, wr, waddr, wdata, rd, raddr,
        input  alloc_addr, rdata, rdata_vld, free_cnt, used_cnt, err, err_code
    );

    modport slave (
        input  alloc, data, free, free_addr, wr, waddr, wdata, rd, raddr,
        output alloc_addr, rdata, rdata_vld, free_cnt, used_cnt, err, err_code
    );
endinterface

// File: rtl/heap_alloc.sv
// BRAM-backed heap allocator: bump allocation until full, then a LIFO free list
// threaded through the free cells, with sticky coded errors that halt the block.
module heap_alloc #(
    parameter int unsigned        DATA_SZ = 16,
    parameter int unsigned        ADDR_SZ = 8,
    parameter int unsigned        MEM_MAX = 1 << ADDR_SZ,
    parameter logic [DATA_SZ-1:0] BASE    = 16'h5000,
    parameter logic [DATA_SZ-1:0] UNDEF   = 16'h0000,
    parameter logic [DATA_SZ-1:0] NIL     = 16'h0001
) (
    input  logic         clk,
    input  logic         rst_n,
    heap_alloc_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDR_SZ;
    localparam int unsigned TAG_W = DATA_SZ - ADDR_SZ;

    typedef logic [ADDR_SZ-1:0] idx_t;
    typedef logic [ADDR_SZ:0]   cnt_t;
    typedef logic [DATA_SZ-1:0] word_t;

    localparam cnt_t TOP_MAX = cnt_t'(MEM_MAX);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    cnt_t       top_q, free_cnt_q;
    word_t      next_q, addr_q, addr_d;
    logic       fwd_q, vld_q;

    word_t      mem [DEPTH];
    word_t      rd_q;

    logic       do_pop, do_bump, do_push, do_rd;
    logic       mem_we;
    idx_t       mem_widx, mem_ridx;
    word_t      mem_wdat;
    logic [1:0] err_c;
    logic       ptr_req, mem_req;
    word_t      next_eff;

    function automatic idx_t idx_of(input word_t a);
        return a[ADDR_SZ-1:0];
    endfunction

    function automatic logic in_heap(input word_t a, input cnt_t lim);
        return (a[DATA_SZ-1:ADDR_SZ] == BASE[DATA_SZ-1:ADDR_SZ]) &&
               ({1'b0, a[ADDR_SZ-1:0]} < lim);
    endfunction

    // Right after a pop the list head lives in the BRAM read register, not in next_q.
    assign next_eff = fwd_q ? rd_q : next_q;
    assign ptr_req  = bus.alloc | bus.free;
    assign mem_req  = bus.rd | bus.wr;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        addr_d   = UNDEF;
        do_pop   = 1'b0;
        do_bump  = 1'b0;
        do_push  = 1'b0;
        do_rd    = 1'b0;
        mem_we   = 1'b0;
        mem_widx = idx_of(bus.waddr);
        mem_wdat = bus.wdata;
        mem_ridx = idx_of(bus.raddr);
        err_c    = 2'd0;

        if (state_q == ST_RUN) begin
            if (ptr_req && mem_req)
                err_c = 2'd1;
            else if (bus.alloc && !bus.free && free_cnt_q == '0 && top_q == TOP_MAX)
                err_c = 2'd2;
            else if ((bus.free && !(in_heap(bus.free_addr, top_q) &&
                                    bus.free_addr != UNDEF && bus.free_addr != NIL)) ||
                     (bus.rd && !in_heap(bus.raddr, top_q)) ||
                     (bus.wr && !in_heap(bus.waddr, top_q)))
                err_c = 2'd3;

            if (err_c != 2'd0) begin
                state_d = ST_HALT;
                code_d  = err_c;
            end else if (bus.alloc && bus.free) begin
                mem_we   = 1'b1;
                mem_widx = idx_of(bus.free_addr);
                mem_wdat = bus.data;
                addr_d   = bus.free_addr;
            end else if (bus.alloc) begin
                mem_we   = 1'b1;
                mem_wdat = bus.data;
                if (free_cnt_q != '0) begin
                    // Overwrite the popped cell while reading its old link in the same cycle.
                    do_pop   = 1'b1;
                    mem_widx = idx_of(next_eff);
                    mem_ridx = idx_of(next_eff);
                    addr_d   = next_eff;
                end else begin
                    do_bump  = 1'b1;
                    mem_widx = top_q[ADDR_SZ-1:0];
                    addr_d   = BASE | {{TAG_W{1'b0}}, top_q[ADDR_SZ-1:0]};
                end
            end else if (bus.free) begin
                do_push  = 1'b1;
                mem_we   = 1'b1;
                mem_widx = idx_of(bus.free_addr);
                mem_wdat = next_eff;
            end else begin
                mem_we = bus.wr;
                do_rd  = bus.rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            code_q     <= 2'd0;
            top_q      <= '0;
            free_cnt_q <= '0;
            next_q     <= NIL;
            fwd_q      <= 1'b0;
            addr_q     <= UNDEF;
            vld_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            addr_q  <= addr_d;
            vld_q   <= do_rd;
            fwd_q   <= do_pop;
            next_q  <= do_push ? bus.free_addr : next_eff;
            if (do_bump)
                top_q <= top_q + 1'b1;
            if (do_push)
                free_cnt_q <= free_cnt_q + 1'b1;
            else if (do_pop)
                free_cnt_q <= free_cnt_q - 1'b1;
        end
    end

    // Heap storage: contents survive reset, read-before-write on a shared index.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_widx] <= mem_wdat;
        rd_q <= mem[mem_ridx];
    end

    assign bus.alloc_addr = addr_q;
    assign bus.rdata      = rd_q;
    assign bus.rdata_vld  = vld_q;
    assign bus.free_cnt   = free_cnt_q;
    assign bus.used_cnt   = top_q - free_cnt_q;
    assign bus.err        = (state_q == ST_HALT);
    assign bus.err_code   = code_q;

endmodule

// File: tb/tb_heap_alloc.sv
// Bench for heap_alloc: directed scenarios then randomized traffic against a
// queue-based reference model of the heap.
module tb_heap_alloc;
  localparam int          AW    = 4;
  localparam int          MM    = 4;
  localparam logic [15:0] BASE  = 16'h5000;
  localparam logic [15:0] UNDEF = 16'h0000;
  localparam logic [15:0] NIL   = 16'h0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  heap_alloc_if #(.DATA_SZ(16), .ADDR_SZ(AW)) bus ();

  heap_alloc #(
    .DATA_SZ(16), .ADDR_SZ(AW), .MEM_MAX(MM),
    .BASE(BASE), .UNDEF(UNDEF), .NIL(NIL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // reference model: bump count, LIFO free list, set of live cells, cell contents
  int          m_top;
  logic [15:0] m_fl[$];
  logic [15:0] m_live[$];
  logic [15:0] m_mem[16];
  bit          m_halt;
  logic [1:0]  m_code;
  logic [15:0] e_addr;
  bit          e_vld;
  logic [15:0] e_rdata;

  function automatic bit m_inheap(input logic [15:0] a);
    return ((a & 16'hFFF0) == BASE) && (int'(a & 16'h000F) < m_top);
  endfunction

  function automatic int ix(input logic [15:0] a);
    return int'(a & 16'h000F);
  endfunction

  task automatic model_reset();
    m_top = 0;
    m_fl.delete();
    m_live.delete();
    m_halt = 0;
    m_code = 2'd0;
    e_addr = UNDEF;
    e_vld = 0;
  endtask

  task automatic model_step();
    logic [1:0]  code;
    logic [15:0] a;
    e_addr = UNDEF;
    e_vld = 0;
    if (m_halt) return;
    code = 2'd0;
    if ((bus.alloc || bus.free) && (bus.rd || bus.wr)) code = 2'd1;
    else if (bus.alloc && !bus.free && m_fl.size() == 0 && m_top == MM) code = 2'd2;
    else if ((bus.free && !(m_inheap(bus.free_addr) && bus.free_addr != UNDEF && bus.free_addr != NIL)) ||
             (bus.rd && !m_inheap(bus.raddr)) || (bus.wr && !m_inheap(bus.waddr))) code = 2'd3;
    if (code != 2'd0) begin
      m_halt = 1;
      m_code = code;
      return;
    end
    if (bus.alloc && bus.free) begin
      m_mem[ix(bus.free_addr)] = bus.data;
      e_addr = bus.free_addr;
    end else if (bus.alloc) begin
      if (m_fl.size() > 0) a = m_fl.pop_front();
      else begin
        a = BASE | 16'(m_top);
        m_top++;
      end
      m_mem[ix(a)] = bus.data;
      m_live.push_back(a);
      e_addr = a;
    end else if (bus.free) begin
      m_mem[ix(bus.free_addr)] = (m_fl.size() > 0) ? m_fl[0] : NIL;
      m_fl.push_front(bus.free_addr);
      for (int k = 0; k < m_live.size(); k++)
        if (m_live[k] == bus.free_addr) begin
          m_live.delete(k);
          break;
        end
    end
    if (bus.rd) begin
      e_vld = 1;
      e_rdata = m_mem[ix(bus.raddr)];
    end
    if (bus.wr) m_mem[ix(bus.waddr)] = bus.wdata;
  endtask

  task automatic check_outs();
    chk("addr", bus.alloc_addr, e_addr);
    chk("rdata_vld", bus.rdata_vld, e_vld);
    if (e_vld) chk("rdata", bus.rdata, e_rdata);
    chk("err", bus.err, m_halt);
    chk("err_code", bus.err_code, m_code);
    chk("free_cnt", bus.free_cnt, m_fl.size());
    chk("used_cnt", bus.used_cnt, m_top - m_fl.size());
  endtask

  task automatic idle();
    bus.alloc = 0; bus.data = '0; bus.free = 0; bus.free_addr = '0;
    bus.wr = 0; bus.waddr = '0; bus.wdata = '0; bus.rd = 0; bus.raddr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_outs();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    check_outs();
  endtask

  task automatic op_alloc(input logic [15:0] d);
    bus.alloc = 1; bus.data = d; tick();
  endtask
  task automatic op_free(input logic [15:0] a);
    bus.free = 1; bus.free_addr = a; tick();
  endtask
  task automatic op_pass(input logic [15:0] a, input logic [15:0] d);
    bus.alloc = 1; bus.free = 1; bus.free_addr = a; bus.data = d; tick();
  endtask
  task automatic op_rd(input logic [15:0] a);
    bus.rd = 1; bus.raddr = a; tick();
  endtask
  task automatic op_wr(input logic [15:0] a, input logic [15:0] d);
    bus.wr = 1; bus.waddr = a; bus.wdata = d; tick();
  endtask

  function automatic logic [15:0] bad_addr();
    case ($urandom_range(0, 3))
      0: return UNDEF;
      1: return NIL;
      2: return BASE | 16'($urandom_range(m_top, 15));
      default: return 16'h6000 | 16'($urandom_range(0, 15));
    endcase
  endfunction

  int halt_cyc;
  int r;

  initial begin
    idle();
    for (int k = 0; k < 16; k++) m_mem[k] = '0;
    do_reset();
    chk("rst_addr", bus.alloc_addr, UNDEF);
    chk("rst_used", bus.used_cnt, 0);

    // bump allocation
    op_alloc(16'h8001); chk("bump0", bus.alloc_addr, 16'h5000);
    op_alloc(16'h8002); chk("bump1", bus.alloc_addr, 16'h5001);
    op_rd(16'h5001);
    chk("rd_vld", bus.rdata_vld, 1);
    chk("rd_val", bus.rdata, 16'h8002);
    chk("used2", bus.used_cnt, 2);

    // free-list LIFO with forwarding on back-to-back pops
    op_alloc(16'h8003);
    op_alloc(16'h8004);
    op_free(16'h5002); chk("fc1", bus.free_cnt, 1);
    op_free(16'h5000); chk("fc2", bus.free_cnt, 2);
    op_alloc(16'h9000); chk("pop0", bus.alloc_addr, 16'h5000); chk("fc3", bus.free_cnt, 1);
    op_alloc(16'h9001); chk("pop1", bus.alloc_addr, 16'h5002); chk("fc4", bus.free_cnt, 0);

    // pass-through
    op_pass(16'h5001, 16'h0004);
    chk("pass_addr", bus.alloc_addr, 16'h5001);
    chk("pass_used", bus.used_cnt, 4);
    op_rd(16'h5001); chk("pass_rd", bus.rdata, 16'h0004);

    // out of memory, then halted
    op_alloc(16'h1111);
    chk("oom_err", bus.err, 1); chk("oom_code", bus.err_code, 2); chk("oom_addr", bus.alloc_addr, UNDEF);
    op_alloc(16'h2222); chk("halt_addr", bus.alloc_addr, UNDEF);
    op_rd(16'h5000); chk("halt_vld", bus.rdata_vld, 0); chk("halt_err", bus.err, 1);

    // bad op, bad address
    do_reset();
    bus.alloc = 1; bus.rd = 1; bus.raddr = 16'h5000; tick();
    chk("badop", bus.err_code, 1);
    do_reset();
    op_alloc(16'h0abc);
    op_rd(16'h5003); chk("badaddr", bus.err_code, 3);

    // reset asserted in the cycle a read is issued
    do_reset();
    op_alloc(16'h1234);
    bus.rd = 1; bus.raddr = 16'h5000; rst_n = 0;
    @(posedge clk); #1;
    model_reset();
    chk("rstrd_vld", bus.rdata_vld, 0);
    chk("rstrd_used", bus.used_cnt, 0);
    chk("rstrd_free", bus.free_cnt, 0);
    check_outs();
    idle();
    rst_n = 1;
    op_alloc(16'h4321); chk("rstrd_alloc", bus.alloc_addr, 16'h5000);

    // randomized traffic
    halt_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        bus.alloc = 1; bus.rd = 1; bus.raddr = BASE;
      end else if (r < 27) begin
        if (m_fl.size() == 0 && m_top == MM && m_live.size() > 0 && $urandom_range(0, 9) != 0) begin
          bus.free = 1; bus.free_addr = m_live[$urandom_range(0, m_live.size() - 1)];
        end else begin
          bus.alloc = 1; bus.data = 16'($urandom);
        end
      end else if (r < 45) begin
        bus.free = 1;
        if (m_live.size() > 0 && $urandom_range(0, 19) != 0)
          bus.free_addr = m_live[$urandom_range(0, m_live.size() - 1)];
        else bus.free_addr = bad_addr();
      end else if (r < 52) begin
        if (m_live.size() > 0) begin
          bus.alloc = 1; bus.free = 1; bus.data = 16'($urandom);
          bus.free_addr = m_live[$urandom_range(0, m_live.size() - 1)];
        end
      end else if (r < 72) begin
        bus.rd = 1;
        if (m_top > 0 && $urandom_range(0, 19) != 0) bus.raddr = BASE | 16'($urandom_range(0, m_top - 1));
        else bus.raddr = bad_addr();
      end else if (r < 85) begin
        if (m_live.size() > 0) begin
          bus.wr = 1; bus.wdata = 16'($urandom);
          bus.waddr = m_live[$urandom_range(0, m_live.size() - 1)];
        end
      end
      tick();
      if (m_halt) halt_cyc++;
      if (halt_cyc >= 3) begin
        halt_cyc = 0;
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/heap_alloc.md
# heap_alloc

Parametrised linked-memory heap allocator with sticky, coded error reporting and occupancy status. It manages a BRAM-backed heap of `MEM_MAX` cells. Cells are handed out from a bump pointer until the heap fills, then recycled through a singly-linked free list threaded through the free cells themselves. It sits between the core's cell-construction logic and the BRAM, so the heap size, tag base and word width can change without touching the core.

## Interface
- `DATA_SZ`, 16: bits per word and per address value.
- `ADDR_SZ`, 8: physical BRAM index width.
- `MEM_MAX`, `1<<ADDR_SZ`: usable cells. Legal range is 1..`2**ADDR_SZ`.
- `BASE`, `16'h5000`: tag bits OR-ed onto every heap address. Its low `ADDR_SZ` bits must be 0.
- `UNDEF`, `16'h0000`: value driven on `o_addr` when no allocation occurs.
- `NIL`, `16'h0001`: free-list terminator.
- `i_clk` in 1: domain clock. All state changes on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_alloc` in 1: allocation request.
- `i_data` in `DATA_SZ`: initial value for the new cell.
- `o_addr` out `DATA_SZ`: allocated address, or `UNDEF`.
- `i_free` in 1: free request.
- `i_addr` in `DATA_SZ`: address being freed.
- `i_wr` in 1: write request.
- `i_waddr` in `DATA_SZ`: write address.
- `i_wdata` in `DATA_SZ`: write data.
- `i_rd` in 1: read request.
- `i_raddr` in `DATA_SZ`: read address.
- `o_rdata` out `DATA_SZ`: read data. Meaningful only while `o_rdata_vld` is high.
- `o_rdata_vld` out 1: read data valid.
- `o_free_cnt` out `ADDR_SZ+1`: cells currently on the free list.
- `o_used_cnt` out `ADDR_SZ+1`: cells currently allocated.
- `o_err` out 1: sticky error / halted.
- `o_err_code` out 2: error cause. 0 = none, 1 = bad op, 2 = out of memory, 3 = bad address.

## Operation
- **State.** The block holds:
  - `top`: count of cells ever carved from the bump region, width `ADDR_SZ+1`.
  - `next`: head of the free list, `NIL` when empty.
  - `free_cnt`.
  - error state.
- **Address mapping.** The physical index is `addr[ADDR_SZ-1:0]`. An address is in-heap iff `addr[DATA_SZ-1:ADDR_SZ] == BASE[DATA_SZ-1:ADDR_SZ]` and its index is below `top`.
- **Ports.** Requests come from two ports:
  - Pointer port: alloc and/or free.
  - Memory port: read or write.
  - Any pointer request together with any memory request in the same cycle is a bad op (code 1).
- **Alloc only, free list non-empty (pop).**
  - Write `i_data` at index(`next`).
  - Issue a BRAM read of index(`next`) to fetch its link.
  - Return `next`; decrement `free_cnt`.
- **Alloc only, free list empty (bump).**
  - If `top == MEM_MAX`: out of memory (code 2).
  - Otherwise write `i_data` at index `top`, return `BASE|top`, increment `top`.
- **Free only (push).**
  - Write `next` into the freed cell's index, set `next <= i_addr`, increment `free_cnt`.
- **Alloc and free together (pass-through).**
  - Write `i_data` at index(`i_addr`) and return `i_addr`.
  - Free list and counters are unchanged.
- **Pop forwarding.** In the cycle after a pop, the effective `next` is the BRAM read data, not the `next` register.
  - Back-to-back pops, or a pop followed by a push, use the forwarded value.
  - The `next` register loads the read data at the end of that cycle.
- **Read.** One-cycle BRAM read. `o_rdata_vld` is 1 in the following cycle.
- **Write.** BRAM write at `i_waddr` index.
- **Bad address (code 3).** A free, read or write whose address is not in-heap. Freeing `UNDEF` or `NIL` is a bad address.
- **Used count.** `o_used_cnt = top - free_cnt`.
- **Error handling.**
  - On any error, the offending request has no effect: no BRAM write, no counter change.
  - `o_err` goes to 1 with the code latched. Priority: bad op > out of memory > bad address.
  - The block then ignores every request until reset.
  - While halted, `o_addr = UNDEF` and `o_rdata_vld = 0`.
- **Out of scope.** Double-free detection.

## Timing
- All outputs are registered. `o_addr`, `o_rdata`/`o_rdata_vld` and error state are visible on the cycle after the request.
- Requests may be issued every cycle with no stalls.
- Reset values:
  - `o_addr = UNDEF`
  - `o_rdata_vld = 0`
  - `o_err = 0`, `o_err_code = 0`
  - `o_free_cnt = 0`, `o_used_cnt = 0`
  - `top = 0`, `next = NIL`
- BRAM contents are not cleared on reset. After reset the heap is logically empty.
- Reset asserted mid-operation:
  - Any pending pop forward and any pending read are discarded. `o_rdata_vld` is forced to 0 asynchronously.
  - The first request after reset release is serviced normally.
- A read issued in the cycle after a pop shares BRAM read data with the pop forward. Reads are only accepted on non-pointer cycles, so there is no conflict.

## Test plan
Common setup: `BASE = 16'h5000`, `ADDR_SZ = 4`, `MEM_MAX = 4`.
- **Bump allocation.** Reset, then alloc `16'h8001`, `16'h8002` on consecutive cycles.
  - `o_addr` is `16'h5000`, then `16'h5001`.
  - Read `16'h5001` returns `16'h8002` with `o_rdata_vld = 1` one cycle later.
  - `o_used_cnt = 2`.
- **Free-list LIFO with forwarding.** Allocate 4 cells, free `16'h5002` then `16'h5000`, then do 2 back-to-back allocs.
  - Allocs return `16'h5000`, then `16'h5002`.
  - `o_free_cnt` goes 1, 2, 1, 0.
- **Pass-through.** Alloc plus free of `16'h5001` in the same cycle, with `i_data = 16'h0004`.
  - `o_addr = 16'h5001`.
  - Counters are unchanged.
  - Reading `16'h5001` gives `16'h0004`.
- **Out of memory.** A 5th alloc with an empty free list.
  - `o_err = 1`, `o_err_code = 2`, `o_addr = UNDEF`.
  - A subsequent alloc or read is ignored, and `o_err` stays 1.
- **Bad op and bad address.** `i_alloc` plus `i_rd` in one cycle gives code 1. After reset, reading `16'h5003` with `top = 1` gives code 3.
- **Reset mid-read.** Pull `i_rst_n` low in the cycle a read is issued.
  - `o_rdata_vld` stays 0.
  - All counters are 0.
  - The next alloc after release returns `16'h5000`.
